// File: rtl/neuron_sched_pkg.sv
// Shared types and helpers for the spike event scheduler.
package neuron_sched_pkg;

  typedef enum logic [1:0] {IDLE, OFFER, LEAK} sched_state_e;
  typedef logic [2:0] ev_idx_t;

  localparam int N_LINES = 8;
  localparam int IN_BASE = 4;

  // Round-robin pick: first set request at or after ptr, wrapping 7 -> 0.
  function automatic ev_idx_t rr_pick(input logic [N_LINES-1:0] req, input ev_idx_t ptr);
    ev_idx_t k;
    ev_idx_t win;
    logic    found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_LINES; i++) begin
      k = ptr + ev_idx_t'(i);
      if (!found && req[k]) begin
        win   = k;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/spike_edge_sync.sv
// Spike line front end: multi-flop synchroniser, rising-edge detect and a
// post-reset warm-up mask so lines already high at reset release stay quiet.
module spike_edge_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] lines,
  output logic [WIDTH-1:0] rise
);

  localparam int WARM = SYNC_STAGES + 1;
  localparam int CW   = $clog2(WARM + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [CW-1:0]                     warm_cnt;

  // Synchroniser chain, previous-value flop and saturating warm-up counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q   <= '0;
      prev_q   <= '0;
      warm_cnt <= '0;
    end else begin
      sync_q[0] <= lines;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      if (warm_cnt != CW'(WARM)) warm_cnt <= warm_cnt + 1'b1;
    end
  end

  assign rise = (warm_cnt == CW'(WARM)) ? (sync_q[SYNC_STAGES-1] & ~prev_q) : '0;

endmodule

// File: rtl/spike_event_scheduler.sv
// Spike event scheduler: captures spike edges into one pending bit per line,
// serialises them round-robin to the core's accumulate port and inserts the
// periodic leak tick between handshakes.
// Optional feature: define SCHED_DROP_CNT_EN to expose a saturating drop_cnt.
module spike_event_scheduler
  import neuron_sched_pkg::*;
#(
  parameter int N_EX        = 4,
  parameter int N_IN        = 4,
  parameter int W_W         = 4,
  parameter int EX_WEIGHT   = 3,
  parameter int IN_WEIGHT   = 2,
  parameter int LEAK_PERIOD = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N_EX-1:0] ex,
  input  logic [N_IN-1:0] in,
  output logic           ev_valid,
  input  logic           ev_ready,
  output ev_idx_t        ev_idx,
  output logic           ev_inhib,
  output logic [W_W-1:0] ev_weight,
  output logic           leak_tick,
  output logic           busy
`ifdef SCHED_DROP_CNT_EN
  ,
  output logic [7:0]     drop_cnt
`endif
);

  localparam int LC_W = $clog2(LEAK_PERIOD);

  sched_state_e         state;
  logic [N_LINES-1:0]   lines, rise, pending, pending_nxt, hs_mask;
  ev_idx_t              rr_ptr, nxt_win;
  logic                 nxt_inhib, hs, wrap, leak_pend;
  logic [LC_W-1:0]      leak_cnt;

  // Inhibitory lines sit directly above the excitatory ones.
  assign lines[N_EX-1:0]       = ex;
  assign lines[N_LINES-1:N_EX] = in;

  spike_edge_sync #(.WIDTH(N_LINES), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .lines (lines),
    .rise  (rise)
  );

  // A new edge on the line being handshaken re-arms it (set beats clear).
  assign hs          = ev_valid & ev_ready;
  assign hs_mask     = hs ? (N_LINES'(1) << ev_idx) : '0;
  assign pending_nxt = (pending & ~hs_mask) | rise;
  assign wrap        = (leak_cnt == LC_W'(LEAK_PERIOD - 1));
  assign busy        = (|pending) | leak_pend | (state != IDLE);

  // From IDLE pick on the registered pending set; back-to-back picks look at
  // the post-handshake set starting just after the line being retired.
  assign nxt_win   = (state == IDLE) ? rr_pick(pending, rr_ptr)
                                     : rr_pick(pending_nxt, ev_idx + 3'd1);
  assign nxt_inhib = (nxt_win >= ev_idx_t'(N_EX));

  // Pending bits, free-running leak timer and merged leak request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending   <= '0;
      leak_cnt  <= '0;
      leak_pend <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      leak_cnt <= wrap ? '0 : leak_cnt + 1'b1;
      if (wrap)               leak_pend <= 1'b1;
      else if (state == LEAK) leak_pend <= 1'b0;
    end
  end

  // Scheduler FSM with registered port outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ev_valid  <= 1'b0;
      ev_idx    <= '0;
      ev_inhib  <= 1'b0;
      ev_weight <= '0;
      leak_tick <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (leak_pend) begin
            state     <= LEAK;
            leak_tick <= 1'b1;
          end else if (|pending) begin
            state     <= OFFER;
            ev_valid  <= 1'b1;
            ev_idx    <= nxt_win;
            ev_inhib  <= nxt_inhib;
            ev_weight <= nxt_inhib ? W_W'(IN_WEIGHT) : W_W'(EX_WEIGHT);
          end
        end
        OFFER: begin
          if (ev_ready) begin
            rr_ptr <= ev_idx + 3'd1;
            if (leak_pend) begin
              state     <= LEAK;
              ev_valid  <= 1'b0;
              leak_tick <= 1'b1;
            end else if (|pending_nxt) begin
              ev_idx    <= nxt_win;
              ev_inhib  <= nxt_inhib;
              ev_weight <= nxt_inhib ? W_W'(IN_WEIGHT) : W_W'(EX_WEIGHT);
            end else begin
              state    <= IDLE;
              ev_valid <= 1'b0;
            end
          end
        end
        LEAK: begin
          state     <= IDLE;
          leak_tick <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_DROP_CNT_EN
  logic [N_LINES-1:0] drop;
  logic [8:0]         drop_sum;

  assign drop     = rise & pending & ~hs_mask;
  assign drop_sum = {1'b0, drop_cnt} + 9'($countones(drop));

  // Saturating count of edges lost to an already-pending line.
  always_ff @(posedge clk) begin
    if (!reset) drop_cnt <= '0;
    else        drop_cnt <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Directed bench for spike_event_scheduler; drop counter checks follow
// SCHED_DROP_CNT_EN.
module tb_spike_event_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ev_ready = 1'b0;
  logic [3:0] ex = '0;
  logic [3:0] in_l = '0;
  logic       ev_valid, ev_inhib, leak_tick, busy;
  logic [2:0] ev_idx;
  logic [3:0] ev_weight;
`ifdef SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spike_event_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .ex        (ex),
    .in        (in_l),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_idx    (ev_idx),
    .ev_inhib  (ev_inhib),
    .ev_weight (ev_weight),
    .leak_tick (leak_tick),
    .busy      (busy)
`ifdef SCHED_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hold reset low for n edges, check the cleared outputs, then release.
  task automatic apply_reset(input int n);
    reset = 1'b0;
    repeat (n) step();
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_leak", 32'(leak_tick), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(ev_idx), 0);
    chk("rst_weight", 32'(ev_weight), 0);
`ifdef SCHED_DROP_CNT_EN
    chk("rst_drop", 32'(drop_cnt), 0);
`endif
    reset = 1'b1;
  endtask

  initial begin
    int hs;

    // 1: lines held high through reset emit nothing; leak every 16 cycles.
    ex = 4'hF; ev_ready = 1'b1;
    step();
    apply_reset(10);
    for (int i = 1; i <= 34; i++) begin
      step();
      chk("t1_valid", 32'(ev_valid), 0);
      chk("t1_leak", 32'(leak_tick), 32'(i == 17 || i == 33));
      chk("t1_busy", 32'(busy), 32'(i == 16 || i == 17 || i == 32 || i == 33));
    end

    // 2: single excitatory edge, 4-cycle latency, one handshake.
    ex = '0;
    apply_reset(2);
    repeat (4) step();
    ex[2] = 1'b1;
    hs = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t2_valid", 32'(ev_valid), 32'(k == 4));
      if (ev_valid && ev_ready) hs++;
      if (k == 4) begin
        chk("t2_idx", 32'(ev_idx), 2);
        chk("t2_inhib", 32'(ev_inhib), 0);
        chk("t2_weight", 32'(ev_weight), 3);
      end
      if (k == 3) chk("t2_busy_on", 32'(busy), 1);
      if (k == 6) chk("t2_busy_off", 32'(busy), 0);
    end
    chk("t2_hs_count", 32'(hs), 1);

    // 3: four simultaneous edges drain back-to-back in index order.
    ex = '0;
    apply_reset(2);
    repeat (4) step();
    ex = 4'b1110; in_l = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t3_valid", 32'(ev_valid), 32'(k >= 4 && k <= 7));
      if (k >= 4 && k <= 7) begin
        chk("t3_idx", 32'(ev_idx), 32'(k - 3));
        chk("t3_inhib", 32'(ev_inhib), 32'(k == 7));
        chk("t3_weight", 32'(ev_weight), (k == 7) ? 2 : 3);
      end
    end

    // 4/5: stalled offer holds payload, repeat edge dropped, leak waits for
    // the handshake and fires the cycle after it.
    ex = '0; in_l = '0; ev_ready = 1'b0;
    apply_reset(2);
    repeat (4) step();
    ex[0] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 2) ex[0] = 1'b0;
      if (k == 5) ex[0] = 1'b1;
      chk("t4_valid", 32'(ev_valid), 32'(k >= 4));
      if (k >= 4) begin
        chk("t4_idx", 32'(ev_idx), 0);
        chk("t4_weight", 32'(ev_weight), 3);
        chk("t4_leak_held", 32'(leak_tick), 0);
      end
    end
    chk("t4_busy", 32'(busy), 1);
`ifdef SCHED_DROP_CNT_EN
    chk("t4_drop_cnt", 32'(drop_cnt), 1);
`endif
    ev_ready = 1'b1;
    hs = 0;
    for (int j = 0; j <= 5; j++) begin
      if (ev_valid && ev_ready) hs++;
      chk("t5_leak_after_hs", 32'(leak_tick), 32'(j == 1));
      step();
    end
    chk("t4_hs_count", 32'(hs), 1);

    // 6: reset pulse during a stalled offer discards it for good.
    ex = '0; ev_ready = 1'b0;
    apply_reset(2);
    repeat (4) step();
    ex[1] = 1'b1;
    repeat (5) step();
    chk("t6_offer", 32'(ev_valid), 1);
    chk("t6_offer_idx", 32'(ev_idx), 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("t6_valid_cleared", 32'(ev_valid), 0);
    chk("t6_busy_cleared", 32'(busy), 0);
    ev_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t6_no_reissue", 32'(ev_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
